l2_line_reader: RTL and testbench
=================================

Name: l2_line_reader

Overview:
- Read-direction counterpart of the L2 line-merge path. Serves 128-bit L1 line-read requests from 256-bit L2 lines by selecting the half addressed by bit 4.
- Sits between the L1 miss interface and the L2 core lookup.
- Holds a one-entry 256-bit line buffer so that back-to-back L1 reads of both halves of one L2 line cost a single L2 lookup.
- Buffer coherence with the L2 write path is maintained through an invalidate port.

Parameters:
- ADDR_W, 16, address width (lc3b_word).
- L1_LINE_W, 128, L1 line width (lc3b_c_line).
- L2_LINE_W, 256, L2 line width (lc3b_c2_line).
- CNT_W, 16, width of the buffer-hit statistics counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- l1_read  in  1  L1 line-read request; held high until l1_resp.
- l1_address  in  16  byte address of the request; [15:5] is the L2 tag+set, [4] is the half select.
- l1_rdata  out  128  selected half-line; registered, valid when l1_resp=1, held until the next response.
- l1_resp  out  1  one-cycle response pulse.
- l2_req  out  1  L2 lookup request; held until l2_ready.
- l2_address  out  16  latched request address, with [4:0] forced to 0.
- l2_ready  in  1  l2_line is valid this cycle (hit, or fill complete).
- l2_line  in  256  full L2 line.
- inval  in  1  L2 write path modified a line this cycle.
- inval_address  in  16  address of the modified line; only [15:5] compared.
- busy  out  1  high in LOOKUP and RESPOND.
- hit_count  out  CNT_W  number of requests served from the buffer; saturates at all-ones.

Behaviour:
- Reset (reset_n=0 at an edge), from any state including mid-LOOKUP:
  - state=IDLE; l2_req=0, l1_resp=0, l1_rdata=0, l2_address=0, busy=0, hit_count=0; buffer valid=0.
  - A pending L2 lookup is abandoned; any l2_ready arriving after reset is ignored.
- Internal state: buf_line[255:0], buf_tag[10:0], buf_valid, req_addr[15:0].
- State IDLE:
  - On l1_read=1, latch req_addr=l1_address.
  - Buffer hit: buf_valid=1, buf_tag==l1_address[15:5], and NOT (inval=1 with inval_address[15:5]==l1_address[15:5]).
    - Go to RESPOND.
    - Register l1_rdata = l1_address[4] ? buf_line[255:128] : buf_line[127:0].
    - Increment hit_count (saturating).
  - Otherwise go to LOOKUP.
- State LOOKUP:
  - l2_req=1, l2_address={req_addr[15:5],5'b0}.
  - On l2_ready=1:
    - buf_line=l2_line, buf_tag=req_addr[15:5], buf_valid=1.
    - l1_rdata = selected half of l2_line per req_addr[4].
    - Go to RESPOND; l2_req drops in the following cycle.
- State RESPOND: l1_resp=1 for exactly one cycle, then IDLE. An l1_read seen in the next IDLE cycle is a new request.
- Latency:
  - Buffer hit: l1_resp in cycle N+1 for a request first seen in IDLE at cycle N.
  - Miss: l1_resp in the cycle after l2_ready; l2_req first asserted in cycle N+1.
- Invalidate: if buf_valid and inval_address[15:5]==buf_tag, clear buf_valid at the edge. Effect in each state:
  - Same cycle as an IDLE hit check on that tag: the request is treated as a miss.
  - Same cycle as an l2_ready capture in LOOKUP for the same tag: the capture wins and buf_valid=1, because l2_line is the current data.
  - In RESPOND: the already-registered l1_rdata is unaffected.
- l1_read dropping during LOOKUP is a protocol violation. The block completes the lookup, fills the buffer and pulses l1_resp regardless.
- l1_address changes while busy are ignored; only the latched req_addr is used.

Test Plan:
- Reset, then read 0x1230: l2_req=1 with l2_address=0x1220 from cycle 1. Drive l2_ready with l2_line={128'hB,128'hA} at cycle 3 -> l1_resp=1 at cycle 4 with l1_rdata=128'hB, hit_count=0.
- Then read 0x1220 -> no l2_req; l1_resp one cycle after the request with l1_rdata=128'hA; hit_count=1.
- Buffer holds tag of 0x1220; assert inval with inval_address=0x123F in the same cycle as a read of 0x1220 -> treated as miss, l2_req=1, new line fetched, buf_valid=1 afterwards.
- In LOOKUP for 0x4000, assert inval for 0x4000 together with l2_ready -> buffer valid; the next read of 0x4010 hits (no l2_req).
- Deassert reset_n for one cycle mid-LOOKUP, then pulse l2_ready -> no l1_resp, l2_req=0, state IDLE; the following read of the same address misses.
- Force hit_count to all-ones via 2^16 buffer hits (or CNT_W=4 with 16 hits), then one more hit -> the count holds at all-ones.

Source files
------------

// File: rtl/l2_line_reader.sv
// Serves 128-bit L1 line reads from 256-bit L2 lines through a one-entry line buffer,
// so both halves of one L2 line cost a single L2 lookup.
module l2_line_reader #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned L1_LINE_W = 128,
    parameter int unsigned L2_LINE_W = 256,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 l1_read,
    input  logic [ADDR_W-1:0]    l1_address,
    output logic [L1_LINE_W-1:0] l1_rdata,
    output logic                 l1_resp,
    output logic                 l2_req,
    output logic [ADDR_W-1:0]    l2_address,
    input  logic                 l2_ready,
    input  logic [L2_LINE_W-1:0] l2_line,
    input  logic                 inval,
    input  logic [ADDR_W-1:0]    inval_address,
    output logic                 busy,
    output logic [CNT_W-1:0]     hit_count
);

    localparam int unsigned TagW = ADDR_W - 5;

    typedef enum logic [1:0] {StIdle, StLookup, StRespond} state_e;

    state_e                 state;
    logic [L2_LINE_W-1:0]   buf_line;
    logic [TagW-1:0]        buf_tag;
    logic                   buf_valid;
    logic [ADDR_W-1:0]      req_addr;

    logic [TagW-1:0] l1_tag;
    logic [TagW-1:0] inval_tag;
    logic [TagW-1:0] req_tag;
    logic            inval_buf;
    logic            inval_req;
    logic            buf_hit;

    assign l1_tag    = l1_address[ADDR_W-1:5];
    assign inval_tag = inval_address[ADDR_W-1:5];
    assign req_tag   = req_addr[ADDR_W-1:5];
    assign inval_buf = inval && buf_valid && (inval_tag == buf_tag);
    // A write to the requested line in the same cycle makes the buffered copy stale.
    assign inval_req = inval && (inval_tag == l1_tag);
    assign buf_hit   = buf_valid && (buf_tag == l1_tag) && !inval_req;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= StIdle;
            l2_req     <= 1'b0;
            l1_resp    <= 1'b0;
            l1_rdata   <= '0;
            l2_address <= '0;
            busy       <= 1'b0;
            hit_count  <= '0;
            buf_valid  <= 1'b0;
            buf_line   <= '0;
            buf_tag    <= '0;
            req_addr   <= '0;
        end else begin
            if (inval_buf) begin
                buf_valid <= 1'b0;
            end
            case (state)
                StIdle: begin
                    if (l1_read) begin
                        req_addr   <= l1_address;
                        l2_address <= {l1_tag, 5'b0};
                        busy       <= 1'b1;
                        if (buf_hit) begin
                            l1_rdata <= l1_address[4] ? buf_line[L2_LINE_W-1:L1_LINE_W]
                                                      : buf_line[L1_LINE_W-1:0];
                            l1_resp  <= 1'b1;
                            state    <= StRespond;
                            if (hit_count != '1) begin
                                hit_count <= hit_count + CNT_W'(1);
                            end
                        end else begin
                            l2_req <= 1'b1;
                            state  <= StLookup;
                        end
                    end
                end
                StLookup: begin
                    if (l2_ready) begin
                        // Fill wins over a same-cycle invalidate: l2_line is the current data.
                        buf_line  <= l2_line;
                        buf_tag   <= req_tag;
                        buf_valid <= 1'b1;
                        l1_rdata  <= req_addr[4] ? l2_line[L2_LINE_W-1:L1_LINE_W]
                                                 : l2_line[L1_LINE_W-1:0];
                        l2_req    <= 1'b0;
                        l1_resp   <= 1'b1;
                        state     <= StRespond;
                    end
                end
                StRespond: begin
                    l1_resp <= 1'b0;
                    busy    <= 1'b0;
                    state   <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_line_reader.sv
// Bench for l2_line_reader: directed scenarios plus randomized reads against a
// one-entry line-buffer reference model.
module tb_l2_line_reader;

    localparam int unsigned CntW   = 4;
    localparam int unsigned CntMax = (1 << CntW) - 1;

    logic         clk;
    logic         reset_n;
    logic         l1_read;
    logic [15:0]  l1_address;
    logic [127:0] l1_rdata;
    logic         l1_resp;
    logic         l2_req;
    logic [15:0]  l2_address;
    logic         l2_ready;
    logic [255:0] l2_line;
    logic         inval;
    logic [15:0]  inval_address;
    logic         busy;
    logic [CntW-1:0] hit_count;

    int tests;
    int fails;

    // Reference model: one buffered line and a saturating hit counter.
    logic         m_valid;
    logic [10:0]  m_tag;
    logic [255:0] m_line;
    int           m_hits;

    l2_line_reader #(
        .ADDR_W   (16),
        .L1_LINE_W(128),
        .L2_LINE_W(256),
        .CNT_W    (CntW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .l1_read      (l1_read),
        .l1_address   (l1_address),
        .l1_rdata     (l1_rdata),
        .l1_resp      (l1_resp),
        .l2_req       (l2_req),
        .l2_address   (l2_address),
        .l2_ready     (l2_ready),
        .l2_line      (l2_line),
        .inval        (inval),
        .inval_address(inval_address),
        .busy         (busy),
        .hit_count    (hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    // Entered and left at a negedge. One full L1 read transaction.
    task automatic do_read(input logic [15:0] addr, input logic [255:0] line,
                           input logic inv, input logic [15:0] inv_addr,
                           input int delay, input logic inv_ready);
        logic         hit;
        logic [127:0] exp_data;
        hit = m_valid && (m_tag == addr[15:5]) && !(inv && (inv_addr[15:5] == addr[15:5]));
        if (inv && m_valid && (inv_addr[15:5] == m_tag)) m_valid = 1'b0;
        l1_read       = 1'b1;
        l1_address    = addr;
        inval         = inv;
        inval_address = inv_addr;
        @(posedge clk);
        #1;
        inval      = 1'b0;
        l1_address = 16'($urandom);
        @(negedge clk);
        if (hit) begin
            if (m_hits < CntMax) m_hits++;
            exp_data = addr[4] ? m_line[255:128] : m_line[127:0];
            check("hit_resp", 256'(l1_resp), 256'(1'b1));
            check("hit_no_l2_req", 256'(l2_req), 256'(1'b0));
            check("hit_rdata", 256'(l1_rdata), 256'(exp_data));
            check("hit_busy", 256'(busy), 256'(1'b1));
        end else begin
            check("miss_l2_req", 256'(l2_req), 256'(1'b1));
            check("miss_l2_addr", 256'(l2_address), 256'({addr[15:5], 5'b0}));
            check("miss_no_resp", 256'(l1_resp), 256'(1'b0));
            check("miss_busy", 256'(busy), 256'(1'b1));
            for (int i = 0; i < delay; i++) begin
                @(posedge clk);
                @(negedge clk);
                check("wait_l2_req", 256'(l2_req), 256'(1'b1));
                check("wait_no_resp", 256'(l1_resp), 256'(1'b0));
            end
            l2_ready      = 1'b1;
            l2_line       = line;
            inval         = inv_ready;
            inval_address = addr;
            @(posedge clk);
            #1;
            l2_ready = 1'b0;
            l2_line  = rand_line();
            inval    = 1'b0;
            m_valid  = 1'b1;
            m_tag    = addr[15:5];
            m_line   = line;
            exp_data = addr[4] ? line[255:128] : line[127:0];
            @(negedge clk);
            check("fill_resp", 256'(l1_resp), 256'(1'b1));
            check("fill_l2_req_drop", 256'(l2_req), 256'(1'b0));
            check("fill_rdata", 256'(l1_rdata), 256'(exp_data));
        end
        check("hit_count", 256'(hit_count), 256'(m_hits));
        l1_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("resp_one_cycle", 256'(l1_resp), 256'(1'b0));
        check("idle_not_busy", 256'(busy), 256'(1'b0));
        check("rdata_held", 256'(l1_rdata), 256'(exp_data));
    endtask

    initial begin
        logic [15:0] addr;
        logic [15:0] pool [4];
        tests = 0;
        fails = 0;
        m_valid = 1'b0;
        m_tag = '0;
        m_line = '0;
        m_hits = 0;
        reset_n = 1'b0;
        l1_read = 1'b0;
        l1_address = '0;
        l2_ready = 1'b0;
        l2_line = '0;
        inval = 1'b0;
        inval_address = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_l2_req", 256'(l2_req), 256'(1'b0));
        check("rst_l1_resp", 256'(l1_resp), 256'(1'b0));
        check("rst_l1_rdata", 256'(l1_rdata), 256'(0));
        check("rst_l2_addr", 256'(l2_address), 256'(0));
        check("rst_busy", 256'(busy), 256'(1'b0));
        check("rst_hit_count", 256'(hit_count), 256'(0));

        // Miss on 0x1230, ready two cycles after l2_req rises, upper half returned.
        do_read(16'h1230, {128'hB, 128'hA}, 1'b0, 16'h0, 2, 1'b0);
        do_read(16'h1220, rand_line(), 1'b0, 16'h0, 0, 1'b0);
        // Same-cycle invalidate turns a would-be hit into a miss; refill stays valid.
        do_read(16'h1220, rand_line(), 1'b1, 16'h123F, 1, 1'b0);
        do_read(16'h1230, rand_line(), 1'b0, 16'h0, 0, 1'b0);
        // Invalidate together with l2_ready: the fill wins.
        do_read(16'h4000, rand_line(), 1'b0, 16'h0, 1, 1'b1);
        do_read(16'h4010, rand_line(), 1'b0, 16'h0, 0, 1'b0);

        // Reset in the middle of a lookup abandons it.
        l1_read = 1'b1;
        l1_address = 16'h5000;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_rst_l2_req", 256'(l2_req), 256'(1'b1));
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        l1_read = 1'b0;
        m_valid = 1'b0;
        m_hits = 0;
        @(negedge clk);
        check("midrst_l2_req", 256'(l2_req), 256'(1'b0));
        check("midrst_busy", 256'(busy), 256'(1'b0));
        check("midrst_hit_count", 256'(hit_count), 256'(0));
        l2_ready = 1'b1;
        l2_line = rand_line();
        @(posedge clk);
        #1;
        l2_ready = 1'b0;
        @(negedge clk);
        check("late_ready_no_resp", 256'(l1_resp), 256'(1'b0));
        check("late_ready_l2_req", 256'(l2_req), 256'(1'b0));
        check("late_ready_busy", 256'(busy), 256'(1'b0));
        do_read(16'h5000, rand_line(), 1'b0, 16'h0, 0, 1'b0);

        // Drive the counter past all-ones.
        for (int i = 0; i < CntMax + 3; i++) begin
            do_read(16'h5000 | 16'((i % 2) << 4), rand_line(), 1'b0, 16'h0, 0, 1'b0);
        end
        check("hit_count_saturated", 256'(hit_count), 256'(CntMax));

        pool[0] = 16'h1200;
        pool[1] = 16'h1220;
        pool[2] = 16'hA7E0;
        pool[3] = 16'h0040;
        for (int i = 0; i < 60; i++) begin
            addr = pool[$urandom_range(3)] | 16'($urandom_range(31));
            do_read(addr, rand_line(), ($urandom_range(3) == 0),
                    pool[$urandom_range(3)] | 16'($urandom_range(31)),
                    int'($urandom_range(3)), 1'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
